// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit hex seven-segment driver with double-buffered value.
// Ports: clk, rst (async active-high), enable (scan/dark), load (capture value/dp_in to shadow),
//        value[4*NUM_DIGITS] packed hex, dp_in[NUM_DIGITS]; outputs seg{g..a}, dp, an[NUM_DIGITS]
//        (all registered) and frame_done (one-cycle pulse at the end of the last digit slot).
// Optional macro LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 is never blanked).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD_CYCLES   = 1,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic SEG_OFF = ACTIVE_LOW_SEG != 0;
  localparam logic AN_OFF = ACTIVE_LOW_AN != 0;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val, r_disp_val;
  logic [NUM_DIGITS-1:0] r_shadow_dp, r_disp_dp;
  logic w_tick, w_last, w_wrap;
  logic [3:0] w_nib;
  logic [6:0] w_dec, w_seg_raw;
  logic [NUM_DIGITS-1:0] w_an_act;
  assign w_tick = enable && r_presc == PW'(CLK_DIV - 1);
  assign w_last = r_idx == IW'(NUM_DIGITS - 1);
  assign w_wrap = w_tick && w_last;
  assign w_nib = r_disp_val[{r_idx, 2'b00} +: 4];
  // Decode table is in active-low form; polarity is applied afterwards.
  always_comb begin
    w_dec = 7'b1111111;
    case (w_nib)
      4'h0: w_dec = 7'b1000000;
      4'h1: w_dec = 7'b1111001;
      4'h2: w_dec = 7'b0100100;
      4'h3: w_dec = 7'b0110000;
      4'h4: w_dec = 7'b0011001;
      4'h5: w_dec = 7'b0010010;
      4'h6: w_dec = 7'b0000010;
      4'h7: w_dec = 7'b1111000;
      4'h8: w_dec = 7'b0000000;
      4'h9: w_dec = 7'b0010000;
      4'hA: w_dec = 7'b0001000;
      4'hB: w_dec = 7'b0000011;
      4'hC: w_dec = 7'b1000110;
      4'hD: w_dec = 7'b0100001;
      4'hE: w_dec = 7'b0000110;
      default: w_dec = 7'b0001110;
    endcase
  end
`ifdef LEADING_ZERO_SUPPRESS_EN
  logic w_blank;
  // Blank when this digit and every more-significant digit are zero.
  always_comb begin
    w_blank = r_idx != '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IW'(i) >= r_idx && r_disp_val[4*i +: 4] != 4'd0) w_blank = 1'b0;
  end
  assign w_seg_raw = w_blank ? 7'b1111111 : w_dec;
`else
  assign w_seg_raw = w_dec;
`endif
  // Anode dark for the first GUARD_CYCLES of each slot to avoid ghosting.
  assign w_an_act = enable && r_presc >= PW'(GUARD_CYCLES) ? NUM_DIGITS'(1) << r_idx : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      seg          <= {7{SEG_OFF}};
      dp           <= SEG_OFF;
      an           <= {NUM_DIGITS{AN_OFF}};
      frame_done   <= 1'b0;
    end else begin
      r_presc <= !enable || w_tick ? '0 : r_presc + 1'b1;
      r_idx   <= !enable ? '0 : w_tick ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      // A load coinciding with the frame wrap bypasses the shadow.
      if (w_wrap) begin
        r_disp_val <= load ? value : r_shadow_val;
        r_disp_dp  <= load ? dp_in : r_shadow_dp;
      end
      seg        <= SEG_OFF ? w_seg_raw : ~w_seg_raw;
      dp         <= SEG_OFF ? ~r_disp_dp[r_idx] : r_disp_dp[r_idx];
      an         <= AN_OFF ? ~w_an_act : w_an_act;
      frame_done <= w_wrap;
    end
  end
endmodule
